// File: rtl/adder_result_checker_pkg.sv
// Shared definitions for the adder result checker and its helpers.
//   VEC_W     : stimulus vector width {Cin,B[3:0],A[3:0]}
//   CNT_W     : pass/fail counter width, wide enough to hold SWEEP_LEN
//   SWEEP_LEN : number of vectors in one full sweep
//   state_t   : checker FSM encoding
package adder_result_checker_pkg;

  localparam int VEC_W     = 9;
  localparam int CNT_W     = 10;
  localparam int SWEEP_LEN = 1 << VEC_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/tick_edge_sync.sv
// Brings the slow, asynchronous stimulus tick into the clock50 domain and
// emits a one-cycle strobe on its falling edge. The stimulus changes on the
// rising edge of tick, so the falling edge marks a point where the data is
// settled.
//   clock50 : system clock
//   reset   : synchronous, active-low reset
//   tick    : raw asynchronous tick
//   samp    : one-cycle pulse, three clock50 edges after the raw fall
module tick_edge_sync (
  input  logic clock50,
  input  logic reset,
  input  logic tick,
  output logic samp
);

  logic tick_p0;
  logic tick_p1;
  logic tick_p2;

  // Two synchronizer flops, one history flop, and a registered fall detect.
  always_ff @(posedge clock50) begin
    if (!reset) begin
      tick_p0 <= 1'b0;
      tick_p1 <= 1'b0;
      tick_p2 <= 1'b0;
      samp    <= 1'b0;
    end else begin
      tick_p0 <= tick;
      tick_p1 <= tick_p0;
      tick_p2 <= tick_p1;
      samp    <= tick_p2 & ~tick_p1;
    end
  end

endmodule

// File: rtl/adder_result_checker.sv
// Checks the lookahead and ripple 4-bit adders of the test harness against
// a golden 5-bit sum over one full sweep of all {Cin,B,A} vectors.
//   clock50          : system clock
//   reset            : synchronous, active-low reset
//   tick             : asynchronous stimulus clock
//   start            : one-cycle pulse arming a new sweep
//   A, B, Cin        : stimulus vector
//   sum_l, cout_l    : lookahead adder result
//   sum_r, cout_r    : ripple adder result
//   busy / done      : sweep in progress / sweep complete
//   all_pass         : complete sweep with no failures and no sequence gap
//   pass_count       : vectors where both adders matched
//   fail_count       : vectors where either adder mismatched
//   first_fail_vec   : {Cin,B,A} of the first failure (valid with
//                      first_fail_valid)
//   seq_err          : sticky, a vector was not previous+1
module adder_result_checker
  import adder_result_checker_pkg::*;
(
  input  logic             clock50,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic [3:0]       A,
  input  logic [3:0]       B,
  input  logic             Cin,
  input  logic [3:0]       sum_l,
  input  logic             cout_l,
  input  logic [3:0]       sum_r,
  input  logic             cout_r,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid,
  output logic             seq_err
);

  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(SWEEP_LEN - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [4:0] golden(input logic [VEC_W-1:0] v);
    return 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
  endfunction

  logic             samp;
  logic [VEC_W-1:0] vec_p0;
  logic [4:0]       res_l_p0;
  logic [4:0]       res_r_p0;
  logic             vld_p0;

  state_t           state;
  logic [VEC_W-1:0] idx;
  logic [VEC_W-1:0] prev_vec;

  logic [4:0]       gold;
  logic             res_ok;
  logic [VEC_W-1:0] exp_vec;
  logic             seq_gap;
  logic             eval;
  logic [CNT_W-1:0] fail_after;

  tick_edge_sync u_sync (
    .clock50 (clock50),
    .reset   (reset),
    .tick    (tick),
    .samp    (samp)
  );

  // ---- p0: capture the settled stimulus and both adder results ----
  always_ff @(posedge clock50) begin
    if (samp) begin
      vec_p0   <= {Cin, B, A};
      res_l_p0 <= {cout_l, sum_l};
      res_r_p0 <= {cout_r, sum_r};
    end
  end

  // vld_p0 is the check pulse, one cycle after samp.
  always_ff @(posedge clock50) begin
    if (!reset) vld_p0 <= 1'b0;
    else        vld_p0 <= samp;
  end

  // ---- p1: evaluate the held vector and update FSM/counters ----
  assign gold     = golden(vec_p0);
  assign res_ok   = (res_l_p0 == gold) && (res_r_p0 == gold);
  assign exp_vec  = prev_vec + VEC_W'(1);
  assign seq_gap  = (vec_p0 != exp_vec);
  // A sweep only begins on vector 0; in DONE and IDLE checks are ignored.
  assign eval     = vld_p0 && (((state == ARMED) && (vec_p0 == '0)) || (state == RUN));
  // Fail count as it will stand after this check, used to settle all_pass
  // in the same edge that enters DONE.
  assign fail_after = res_ok ? fail_count : sat_inc(fail_count);

  // start takes priority over a coincident check, which is dropped.
  always_ff @(posedge clock50) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      prev_vec <= '0;
      seq_err  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      all_pass <= 1'b0;
    end else if (start) begin
      state    <= ARMED;
      idx      <= '0;
      prev_vec <= '0;
      seq_err  <= 1'b0;
      busy     <= 1'b1;
      done     <= 1'b0;
      all_pass <= 1'b0;
    end else if (eval) begin
      prev_vec <= vec_p0;
      if (state == ARMED) begin
        state <= RUN;
        idx   <= VEC_W'(1);
      end else begin
        if (seq_gap) seq_err <= 1'b1;
        if (idx == LAST_IDX) begin
          state    <= DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
          all_pass <= (fail_after == '0) && !seq_err && !seq_gap;
        end else begin
          idx <= idx + VEC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock50) begin
    if (!reset || start) begin
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (eval) begin
      if (res_ok) begin
        pass_count <= sat_inc(pass_count);
      end else begin
        fail_count <= sat_inc(fail_count);
        if (!first_fail_valid) begin
          first_fail_vec   <= vec_p0;
          first_fail_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: drives the tick-paced stimulus with a
// behavioural pair of adders (optional stuck-at on the ripple sum bit 2),
// queues the expected verdict of every vector that should be counted and
// matches each counter increment of the DUT against the queue.
module tb_adder_result_checker;
  import adder_result_checker_pkg::*;

  logic             clock50 = 1'b0;
  logic             reset   = 1'b0;
  logic             tick    = 1'b0;
  logic             start   = 1'b0;
  logic [3:0]       A = '0, B = '0, sum_l = '0, sum_r = '0;
  logic             Cin = 1'b0, cout_l = 1'b0, cout_r = 1'b0;
  logic             busy, done, all_pass, first_fail_valid, seq_err;
  logic [CNT_W-1:0] pass_count, fail_count;
  logic [VEC_W-1:0] first_fail_vec;

  int checks = 0;
  int errors = 0;
  bit fault_r = 1'b0;
  bit exp_q[$];
  logic [CNT_W-1:0] prev_p = '0;
  logic [CNT_W-1:0] prev_f = '0;

  adder_result_checker dut (
    .clock50          (clock50),
    .reset            (reset),
    .tick             (tick),
    .start            (start),
    .A                (A),
    .B                (B),
    .Cin              (Cin),
    .sum_l            (sum_l),
    .cout_l           (cout_l),
    .sum_r            (sum_r),
    .cout_r           (cout_r),
    .busy             (busy),
    .done             (done),
    .all_pass         (all_pass),
    .pass_count       (pass_count),
    .fail_count       (fail_count),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid),
    .seq_err          (seq_err)
  );

  always #10 clock50 = ~clock50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic observe(input bit got);
    bit e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_verdict", {31'd0, got}, {31'd0, e});
    end
  endtask

  // Every single-step increase of a counter is one evaluated vector.
  always @(negedge clock50) begin
    if (reset) begin
      if (pass_count == prev_p + CNT_W'(1) && fail_count == prev_f) observe(1'b1);
      else if (fail_count == prev_f + CNT_W'(1) && pass_count == prev_p) observe(1'b0);
    end
    prev_p = pass_count;
    prev_f = fail_count;
  end

  task automatic drive_vec(input logic [VEC_W-1:0] v, input bit counted);
    logic [4:0] g;
    A   = v[3:0];
    B   = v[7:4];
    Cin = v[8];
    g   = {1'b0, A} + {1'b0, B} + {4'd0, Cin};
    {cout_l, sum_l} = g;
    {cout_r, sum_r} = fault_r ? (g & 5'b11011) : g;
    if (counted) exp_q.push_back(!(fault_r && g[2]));
    tick = 1'b1;
    #97;
    tick = 1'b0;
    #143;
  endtask

  task automatic pulse_start();
    @(negedge clock50);
    start = 1'b1;
    exp_q.delete();
    @(negedge clock50);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clock50);
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_all_pass"}, all_pass, 0);
    check({tag, "_pass_count"}, pass_count, 0);
    check({tag, "_fail_count"}, fail_count, 0);
    check({tag, "_ff_vec"}, first_fail_vec, 0);
    check({tag, "_ff_valid"}, first_fail_valid, 0);
    check({tag, "_seq_err"}, seq_err, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (5) @(negedge clock50);
    check_all_zero("reset");
    reset = 1'b1;

    // Full sweep with correct adders
    pulse_start();
    check("t1_armed_busy", busy, 1);
    for (int i = 0; i < 520; i++) drive_vec(VEC_W'(i), i < 512);
    wait_done(20);
    repeat (2) @(negedge clock50);
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);
    check("t1_pass", pass_count, 512);
    check("t1_fail", fail_count, 0);
    check("t1_all_pass", all_pass, 1);
    check("t1_seq_err", seq_err, 0);
    check("t1_ff_valid", first_fail_valid, 0);
    check("t1_drain", exp_q.size(), 0);

    // Arm mid-stream: nothing counts until vector 0
    pulse_start();
    for (int i = 300; i < 512; i++) drive_vec(VEC_W'(i), 1'b0);
    check("t2_wait_busy", busy, 1);
    check("t2_wait_done", done, 0);
    check("t2_wait_pass", pass_count, 0);
    check("t2_wait_fail", fail_count, 0);
    for (int i = 0; i < 520; i++) drive_vec(VEC_W'(i), i < 512);
    wait_done(20);
    check("t2_done", done, 1);
    check("t2_pass", pass_count, 512);
    check("t2_all_pass", all_pass, 1);
    check("t2_drain", exp_q.size(), 0);

    // Ripple sum bit 2 stuck at 0
    fault_r = 1'b1;
    pulse_start();
    for (int i = 0; i < 520; i++) drive_vec(VEC_W'(i), i < 512);
    wait_done(20);
    check("t3_done", done, 1);
    check("t3_ff_valid", first_fail_valid, 1);
    check("t3_ff_vec", first_fail_vec, 9'h004);
    check("t3_fail", fail_count, 256);
    check("t3_pass", pass_count, 256);
    check("t3_all_pass", all_pass, 0);
    check("t3_drain", exp_q.size(), 0);
    fault_r = 1'b0;

    // Skip vector 17: sweep ends on the wrapped vector 0
    pulse_start();
    for (int i = 0; i < 512; i++) if (i != 17) drive_vec(VEC_W'(i), 1'b1);
    check("t4_not_done_yet", done, 0);
    check("t4_seq_err_early", seq_err, 1);
    drive_vec(VEC_W'(0), 1'b1);
    for (int i = 1; i < 8; i++) drive_vec(VEC_W'(i), 1'b0);
    check("t4_done", done, 1);
    check("t4_seq_err", seq_err, 1);
    check("t4_all_pass", all_pass, 0);
    check("t4_pass", pass_count, 512);
    check("t4_total", 32'(pass_count) + 32'(fail_count), 512);
    check("t4_drain", exp_q.size(), 0);

    // Reset in the middle of a sweep
    pulse_start();
    for (int i = 0; i <= 200; i++) drive_vec(VEC_W'(i), 1'b1);
    check("t5_pass_before", pass_count, 201);
    check("t5_drain", exp_q.size(), 0);
    @(negedge clock50);
    reset = 1'b0;
    @(negedge clock50);
    check_all_zero("t5_after_reset");
    reset = 1'b1;
    for (int i = 201; i < 211; i++) drive_vec(VEC_W'(i), 1'b0);
    check("t5_idle_busy", busy, 0);
    check("t5_idle_pass", pass_count, 0);
    check("t5_idle_done", done, 0);

    // start on the same cycle as a check
    pulse_start();
    for (int i = 0; i < 10; i++) drive_vec(VEC_W'(i), 1'b1);
    check("t6_pass_before", pass_count, 10);
    A = 4'd10; B = 4'd0; Cin = 1'b0;
    {cout_l, sum_l} = 5'd10;
    {cout_r, sum_r} = 5'd10;
    tick = 1'b1;
    #97;
    @(negedge clock50);
    tick = 1'b0;
    repeat (4) @(posedge clock50);
    @(negedge clock50);
    start = 1'b1;
    @(negedge clock50);
    start = 1'b0;
    repeat (3) @(negedge clock50);
    check("t6_pass", pass_count, 0);
    check("t6_fail", fail_count, 0);
    check("t6_busy", busy, 1);
    check("t6_done", done, 0);
    check("t6_drain", exp_q.size(), 0);
    #143;
    drive_vec(VEC_W'(0), 1'b1);
    check("t6_rearm_pass", pass_count, 1);
    check("t6_rearm_busy", busy, 1);
    check("t6_rearm_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
